// File: rtl/oscill_sw_pkg.sv
// oscill_sw_pkg: shared defaults, per-bit state encoding and counter-width helper for the switch debouncer
package oscill_sw_pkg;
  localparam int SW_WIDTH          = 10;
  localparam int SW_TICK_DIV       = 50000;
  localparam int SW_DEBOUNCE_TICKS = 10;
  typedef enum logic {SW_STABLE, SW_PENDING} sw_state_e;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/oscill_sw_debounce_if.sv
// oscill_sw_debounce_if: raw switch pins in, debounced level and change/edge pulses out
interface oscill_sw_debounce_if import oscill_sw_pkg::*; #(parameter int WIDTH = SW_WIDTH);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_clean;
  logic             sw_changed;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  modport master (output sw_raw, input sw_clean, sw_changed, sw_rise, sw_fall);
  modport slave  (input sw_raw, output sw_clean, sw_changed, sw_rise, sw_fall);
endinterface

// File: rtl/oscill_sw_debounce_bit.sv
// oscill_sw_debounce_bit: synchronise one switch bit and accept a new level after DEBOUNCE_TICKS stable ticks
module oscill_sw_debounce_bit import oscill_sw_pkg::*; #(
  parameter int   SYNC_STAGES    = 2,
  parameter int   DEBOUNCE_TICKS = SW_DEBOUNCE_TICKS,
  parameter logic RESET_VAL      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_clean
);
  localparam int CW = cnt_w(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_TICKS - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic                   r_clean, w_clean_nxt;
  sw_state_e              w_state;
  // metastability chain bringing the asynchronous pin into clk
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_sync <= {SYNC_STAGES{RESET_VAL}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  // classify the bit and advance the stability counter; any agreeing cycle clears it
  always_comb begin
    w_state     = (r_sync[SYNC_STAGES-1] == r_clean) ? SW_STABLE : SW_PENDING;
    w_cnt_nxt   = r_cnt;
    w_clean_nxt = r_clean;
    if (w_state == SW_STABLE) w_cnt_nxt = '0;
    else if (i_tick) begin
      w_cnt_nxt   = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      w_clean_nxt = (r_cnt == LAST) ? ~r_clean : r_clean;
    end
  end
  // counter and accepted level registers
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt   <= '0;
      r_clean <= RESET_VAL;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_clean <= w_clean_nxt;
    end
  assign o_clean = r_clean;
endmodule

// File: rtl/oscill_sw_debounce.sv
// oscill_sw_debounce: per-bit switch debouncer with shared tick prescaler; OSCILL_SW_EDGE_EN builds rise/fall pulses
module oscill_sw_debounce import oscill_sw_pkg::*; #(
  parameter int               WIDTH          = SW_WIDTH,
  parameter int               SYNC_STAGES    = 2,
  parameter int               TICK_DIV       = SW_TICK_DIV,
  parameter int               DEBOUNCE_TICKS = SW_DEBOUNCE_TICKS,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
  input logic                  clk,
  input logic                  reset_n,
  oscill_sw_debounce_if.slave  sw
);
  localparam int PW = cnt_w(TICK_DIV);
  logic [PW-1:0]    r_pre;
  logic             w_tick;
  logic [WIDTH-1:0] w_clean, r_prev;
  logic             r_changed;
  assign w_tick = (r_pre == PW'(TICK_DIV - 1));
  // free-running prescaler, never restarted by switch activity
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_pre <= '0;
    else          r_pre <= w_tick ? '0 : r_pre + 1'b1;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    oscill_sw_debounce_bit #(
      .SYNC_STAGES   (SYNC_STAGES),
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .RESET_VAL     (RESET_VAL[i])
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .i_tick (w_tick),
      .i_raw  (sw.sw_raw[i]),
      .o_clean(w_clean[i])
    );
  end
  // delayed copy of the clean level so a change is flagged one cycle after it appears
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_prev    <= RESET_VAL;
      r_changed <= 1'b0;
    end else begin
      r_prev    <= w_clean;
      r_changed <= |(w_clean ^ r_prev);
    end
  assign sw.sw_clean   = w_clean;
  assign sw.sw_changed = r_changed;
`ifdef OSCILL_SW_EDGE_EN
  logic [WIDTH-1:0] r_rise, r_fall;
  // per-bit direction pulses aligned with the change pulse
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= w_clean & ~r_prev;
      r_fall <= ~w_clean & r_prev;
    end
  assign sw.sw_rise = r_rise;
  assign sw.sw_fall = r_fall;
`else
  assign sw.sw_rise = '0;
  assign sw.sw_fall = '0;
`endif
endmodule
